// File: rtl/rr_mux_4to1.sv
// 4-to-1 round-robin merging mux; each output word is tagged with its source lane.
// Define RR_MUX_PKT_LOCK_EN to hold a granted lane until its in_last beat.
module rr_mux_4to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [3:0]       in_last,
`endif
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  logic [1:0]       rr_ptr;
  logic             load_ok;
  logic [3:0]       eligible;
  logic [1:0]       grant;
  logic             found;
  logic             accept;
  logic [WIDTH-1:0] grant_data;

  assign load_ok = !out_valid || out_ready;

`ifdef RR_MUX_PKT_LOCK_EN
  localparam logic ARB  = 1'b0;
  localparam logic LOCK = 1'b1;

  logic       state;
  logic [1:0] lock_lane;
  logic       grant_last;

  // While locked only the owning lane may compete.
  assign eligible = (state == LOCK) ?
                    (in_valid & (4'b0001 << lock_lane)) :
                    in_valid;
  assign grant_last = in_last[grant];
`else
  assign eligible = in_valid;
`endif

  // Search from rr_ptr upward, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!found && eligible[rr_ptr + 2'(i)]) begin
        found = 1'b1;
        grant = rr_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_ok && found)
      in_ready = 4'b0001 << grant;
  end

  assign accept = |in_ready;

  always_comb begin
    grant_data = '0;
    unique case (grant)
      2'd0: grant_data = in_data0;
      2'd1: grant_data = in_data1;
      2'd2: grant_data = in_data2;
      2'd3: grant_data = in_data3;
      default: grant_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  // Pointer moves only when a packet ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 2'd0;
      state     <= ARB;
      lock_lane <= 2'd0;
    end else if (accept) begin
      unique case (1'b1)
        (state == ARB): begin
          if (grant_last) begin
            rr_ptr <= grant + 2'd1;
          end else begin
            lock_lane <= grant;
            state     <= LOCK;
          end
        end
        (state == LOCK): begin
          if (grant_last) begin
            rr_ptr <= lock_lane + 2'd1;
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= 2'd0;
    else if (accept)
      rr_ptr <= grant + 2'd1;
  end
`endif

endmodule
